sha256_round_ctrl: RTL and testbench
====================================

// Module: sha256_round_ctrl
// PURPOSE
//  Sequencer for the TRNG SHA-256 conditioning datapath: accepts one 512-bit block per
//  handshake and drives the single-round compression datapath (Ch/Maj/Sigma, W schedule,
//  H registers) through IV load, working-var load, 64 rounds and final add. Control
//  signals only; message and working-variable data stay in the datapath.
// PARAMETERS
//  NUM_ROUNDS  64  compression rounds per block (>=17)
//  MSG_WORDS   16  rounds taking W directly from the message; later rounds use expanded W
//  IDX_W       6   width of dp_round_idx; must satisfy 2**IDX_W >= NUM_ROUNDS
//  CNT_W       8   width of blk_cnt
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  blk_valid      in   1      block (message words) present at the datapath input
//  blk_first      in   1      sampled with accept: first block of a new digest (load IV)
//  blk_ready      out  1      controller idle, can accept a block
//  dp_init_iv     out  1      datapath: H0..H7 <= SHA-256 IV
//  dp_load_vars   out  1      datapath: a..h <= H0..H7, W window <= message
//  dp_round_en    out  1      datapath: perform one round this cycle
//  dp_round_idx   out  IDX_W  round index; selects K constant
//  dp_w_from_msg  out  1      1: W from message window; 0: from sigma expansion
//  dp_final_add   out  1      datapath: H_i <= H_i + working var
//  digest_valid   out  1      H0..H7 hold a completed (intermediate) digest
//  digest_ack     in   1      consumer has taken the digest
//  busy           out  1      state != IDLE
//  blk_cnt        out  CNT_W  blocks completed since last first-block accept
// BEHAVIOUR
//  - All outputs registered (Moore). Reset: state IDLE, every output 0, blk_cnt 0;
//    blk_ready rises on the first clk edge after rst_n release.
//  - States: IDLE -> (INIT if first) -> LOAD -> ROUND x NUM_ROUNDS -> FINAL -> DONE -> IDLE.
//  - Accept = blk_valid & blk_ready (IDLE only); blk_first captured; blk_ready drops the
//    next cycle. blk_valid outside IDLE is ignored, never queued.
//  - INIT: dp_init_iv=1 for 1 cycle; blk_cnt <= 0 on entry. LOAD: dp_load_vars=1, 1 cycle.
//  - ROUND: dp_round_en=1 for NUM_ROUNDS consecutive cycles, dp_round_idx 0..NUM_ROUNDS-1,
//    incrementing by 1; dp_w_from_msg = (idx < MSG_WORDS). Idx returns to 0 on exit.
//  - FINAL: dp_final_add=1, 1 cycle; blk_cnt += 1, saturating at 2**CNT_W-1 (no wrap).
//  - DONE: digest_valid=1, held until digest_ack; ack -> IDLE next edge (digest_valid 0,
//    blk_ready 1 same edge). digest_ack outside DONE ignored.
//  - At most one dp_* strobe high in any cycle.
//  - Latency accept(T0)->digest_valid: T0+68 first block, T0+67 chained block
//    (min 2 cycles DONE->next accept with same-cycle ack).
//  - rst_n low at any time: immediate return to reset values; no partial strobes after.
// CONFIGURATION
//  SHA256_CTRL_ABORT_EN defined: extra input 'abort' (1 bit). abort=1 in INIT, LOAD,
//    ROUND or FINAL -> IDLE next edge, all strobes 0 that edge, no dp_final_add, no
//    digest_valid, blk_cnt unchanged (except INIT's clear, already applied). Ignored in
//    IDLE/DONE. Abort beats accept-related transitions in the same cycle.
//  Not defined: no abort port; sequence always runs to DONE.
// TESTING
//  1. Reset, blk_valid=1 first=1 at T0 -> INIT T1, LOAD T2, round_en T3..T66 idx 0..63,
//     w_from_msg high T3..T18, final_add T67, digest_valid T68, blk_cnt=1.
//  2. Chained block first=0 after ack -> no dp_init_iv; digest_valid at T0+67; blk_cnt=2.
//  3. Hold digest_ack=0 for 20 cycles -> digest_valid and H stable, blk_ready 0, blk_valid
//     ignored; ack -> IDLE next edge, blk_ready=1.
//  4. blk_cnt preload via 255 chained blocks (or CNT_W=2 build, 4 blocks) -> saturates at
//     max; next first=1 block clears it to 0 then 1.
//  5. rst_n low at round idx 30 -> all outputs 0 immediately; new block after release runs
//     full 64 rounds from idx 0.
//  6. (ABORT_EN) abort at round idx 10 -> IDLE next edge, no final_add, blk_cnt unchanged.

Source files
------------

// File: rtl/sha256_round_ctrl.sv
// Control sequencer for a single-round SHA-256 compression datapath: IV load, working-var load,
// NUM_ROUNDS rounds, final add, digest hand-off. Optional abort input under SHA256_CTRL_ABORT_EN.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int MSG_WORDS  = 16,
  parameter int IDX_W      = 6,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHA256_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             blk_valid,
  input  logic             blk_first,
  output logic             blk_ready,
  output logic             dp_init_iv,
  output logic             dp_load_vars,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] dp_round_idx,
  output logic             dp_w_from_msg,
  output logic             dp_final_add,
  output logic             digest_valid,
  input  logic             digest_ack,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W:0]   MSG_LIM  = (IDX_W + 1)'(MSG_WORDS);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t             state_q;
  logic               blk_ready_q;
  logic               dp_init_iv_q;
  logic               dp_load_vars_q;
  logic               dp_round_en_q;
  logic [IDX_W-1:0]   dp_round_idx_q;
  logic               dp_w_from_msg_q;
  logic               dp_final_add_q;
  logic               digest_valid_q;
  logic               busy_q;
  logic [CNT_W-1:0]   blk_cnt_q;

  logic               abort_req;
  logic [IDX_W-1:0]   idx_inc;
  logic               w_from_msg_d;
  logic [CNT_W-1:0]   blk_cnt_d;

`ifdef SHA256_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // idx_inc is only consumed while idx < NUM_ROUNDS-1, so it never overflows IDX_W.
  assign idx_inc      = dp_round_idx_q + 1'b1;
  assign w_from_msg_d = ({1'b0, idx_inc} < MSG_LIM);
  assign blk_cnt_d    = (blk_cnt_q == CNT_MAX) ? blk_cnt_q : blk_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      blk_ready_q     <= 1'b0;
      dp_init_iv_q    <= 1'b0;
      dp_load_vars_q  <= 1'b0;
      dp_round_en_q   <= 1'b0;
      dp_round_idx_q  <= '0;
      dp_w_from_msg_q <= 1'b0;
      dp_final_add_q  <= 1'b0;
      digest_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
      blk_cnt_q       <= '0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them below.
      dp_init_iv_q    <= 1'b0;
      dp_load_vars_q  <= 1'b0;
      dp_round_en_q   <= 1'b0;
      dp_round_idx_q  <= '0;
      dp_w_from_msg_q <= 1'b0;
      dp_final_add_q  <= 1'b0;

      case (state_q)
        S_IDLE: begin
          blk_ready_q <= 1'b1;
          if (blk_valid && blk_ready_q) begin
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (blk_first) begin
              state_q      <= S_INIT;
              dp_init_iv_q <= 1'b1;
              blk_cnt_q    <= '0;
            end else begin
              state_q        <= S_LOAD;
              dp_load_vars_q <= 1'b1;
            end
          end
        end

        S_INIT: begin
          if (abort_req) begin
            state_q     <= S_IDLE;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q        <= S_LOAD;
            dp_load_vars_q <= 1'b1;
          end
        end

        S_LOAD: begin
          if (abort_req) begin
            state_q     <= S_IDLE;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q         <= S_ROUND;
            dp_round_en_q   <= 1'b1;
            dp_round_idx_q  <= '0;
            dp_w_from_msg_q <= (MSG_LIM != '0);
          end
        end

        S_ROUND: begin
          if (abort_req) begin
            state_q     <= S_IDLE;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (dp_round_idx_q == LAST_IDX) begin
            state_q        <= S_FINAL;
            dp_final_add_q <= 1'b1;
          end else begin
            dp_round_en_q   <= 1'b1;
            dp_round_idx_q  <= idx_inc;
            dp_w_from_msg_q <= w_from_msg_d;
          end
        end

        S_FINAL: begin
          if (abort_req) begin
            state_q     <= S_IDLE;
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            state_q        <= S_DONE;
            digest_valid_q <= 1'b1;
            blk_cnt_q      <= blk_cnt_d;
          end
        end

        S_DONE: begin
          if (digest_ack) begin
            state_q        <= S_IDLE;
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
          end
        end

        default: begin
          state_q        <= S_IDLE;
          blk_ready_q    <= 1'b0;
          digest_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign blk_ready     = blk_ready_q;
  assign dp_init_iv    = dp_init_iv_q;
  assign dp_load_vars  = dp_load_vars_q;
  assign dp_round_en   = dp_round_en_q;
  assign dp_round_idx  = dp_round_idx_q;
  assign dp_w_from_msg = dp_w_from_msg_q;
  assign dp_final_add  = dp_final_add_q;
  assign digest_valid  = digest_valid_q;
  assign busy          = busy_q;
  assign blk_cnt       = blk_cnt_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: cycle-exact strobe sequence, chaining, digest hold,
// blk_cnt saturation and asynchronous reset mid-round.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blk_valid = 1'b0;
  logic       blk_first = 1'b0;
  logic       digest_ack = 1'b0;
  logic       blk_ready;
  logic       dp_init_iv;
  logic       dp_load_vars;
  logic       dp_round_en;
  logic [5:0] dp_round_idx;
  logic       dp_w_from_msg;
  logic       dp_final_add;
  logic       digest_valid;
  logic       busy;
  logic [7:0] blk_cnt;

  int checks = 0;
  int errors = 0;
  int blk_no = 0;

  sha256_round_ctrl #(
    .NUM_ROUNDS(64),
    .MSG_WORDS (16),
    .IDX_W     (6),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .blk_valid    (blk_valid),
    .blk_first    (blk_first),
    .blk_ready    (blk_ready),
    .dp_init_iv   (dp_init_iv),
    .dp_load_vars (dp_load_vars),
    .dp_round_en  (dp_round_en),
    .dp_round_idx (dp_round_idx),
    .dp_w_from_msg(dp_w_from_msg),
    .dp_final_add (dp_final_add),
    .digest_valid (digest_valid),
    .digest_ack   (digest_ack),
    .busy         (busy),
    .blk_cnt      (blk_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strobe_cnt();
    return 32'(dp_init_iv) + 32'(dp_load_vars) + 32'(dp_round_en) + 32'(dp_final_add);
  endfunction

  // Runs one block from an idle/ready controller, checking every cycle, holds DONE for
  // hold cycles with blk_valid asserted, then acknowledges.
  task automatic do_block(input logic first, input logic [7:0] cnt_before,
                          input logic [7:0] cnt_after, input int hold);
    blk_valid = 1'b1;
    blk_first = first;
    tick();
    blk_valid = 1'b0;
    blk_first = 1'b0;
    check("accept_ready_drop", blk_ready, 0);
    check("accept_busy", busy, 1);
    if (first) begin
      check("init_iv", dp_init_iv, 1);
      check("init_cnt_clear", blk_cnt, 0);
      check("init_onehot", strobe_cnt(), 1);
      tick();
    end else begin
      check("chain_no_init", dp_init_iv, 0);
    end
    check("load_vars", dp_load_vars, 1);
    check("load_onehot", strobe_cnt(), 1);
    check("load_cnt", blk_cnt, cnt_before);
    tick();
    for (int i = 0; i < 64; i++) begin
      check("round_en", dp_round_en, 1);
      check("round_idx", dp_round_idx, i);
      check("w_from_msg", dp_w_from_msg, (i < 16) ? 1 : 0);
      check("round_onehot", strobe_cnt(), 1);
      tick();
    end
    check("final_add", dp_final_add, 1);
    check("final_onehot", strobe_cnt(), 1);
    check("final_idx_zero", dp_round_idx, 0);
    check("final_no_digest", digest_valid, 0);
    tick();
    check("digest_valid", digest_valid, 1);
    check("done_cnt", blk_cnt, cnt_after);
    check("done_no_strobe", strobe_cnt(), 0);
    blk_valid = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_digest", digest_valid, 1);
      check("hold_ready", blk_ready, 0);
      check("hold_busy", busy, 1);
      check("hold_no_strobe", strobe_cnt(), 0);
      check("hold_cnt", blk_cnt, cnt_after);
    end
    blk_valid = 1'b0;
    digest_ack = 1'b1;
    tick();
    digest_ack = 1'b0;
    check("ack_digest_low", digest_valid, 0);
    check("ack_ready", blk_ready, 1);
    check("ack_busy", busy, 0);
    blk_no++;
    $display("block %0d first=%0d blk_cnt=%0d hold=%0d", blk_no, first, blk_cnt, hold);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_ready", blk_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_digest", digest_valid, 0);
    check("rst_cnt", blk_cnt, 0);
    check("rst_strobes", strobe_cnt(), 0);
    rst_n = 1'b1;
    #1;
    check("rel_ready_low", blk_ready, 0);
    tick();
    check("rel_ready_high", blk_ready, 1);

    // First block, chained block, held digest
    do_block(1'b1, 8'd0, 8'd1, 0);
    do_block(1'b0, 8'd1, 8'd2, 0);
    do_block(1'b0, 8'd2, 8'd3, 20);

    // Fill blk_cnt to saturation, then one more chained block must not wrap
    for (int n = 4; n <= 255; n++) begin
      do_block(1'b0, 8'(n - 1), 8'(n), 0);
    end
    do_block(1'b0, 8'd255, 8'd255, 0);
    do_block(1'b1, 8'd0, 8'd1, 0);

    // Asynchronous reset at round index 30
    blk_valid = 1'b1;
    blk_first = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_first = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 30; i++) tick();
    check("pre_rst_idx", dp_round_idx, 30);
    check("pre_rst_round_en", dp_round_en, 1);
    rst_n = 1'b0;
    #1;
    check("arst_round_en", dp_round_en, 0);
    check("arst_idx", dp_round_idx, 0);
    check("arst_w", dp_w_from_msg, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", blk_ready, 0);
    check("arst_cnt", blk_cnt, 0);
    tick();
    tick();
    check("arst_hold_strobes", strobe_cnt(), 0);
    rst_n = 1'b1;
    #1;
    check("arst_rel_ready_low", blk_ready, 0);
    tick();
    check("arst_rel_ready_high", blk_ready, 1);
    do_block(1'b1, 8'd0, 8'd1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
